// File: rtl/calc_display_if.sv
// Bus between the result register side and the display side of calc_display.
interface calc_display_if;
    logic [15:0] value;
    logic        load;
    logic        hex_mode;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        busy;

    modport master (
        output value, load, hex_mode,
        input  seg, an, dp, busy
    );

    modport slave (
        input  value, load, hex_mode,
        output seg, an, dp, busy
    );
endinterface

// File: rtl/calc_display.sv
// Converts a captured 16-bit result to four digits (sequential double-dabble
// or direct hex) and scans them onto a 4-digit active-low 7-segment display.
module calc_display #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input logic           CLK100MHZ,
    input logic           rst,
    calc_display_if.slave bus
);
    localparam int unsigned CW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t        state_q, state_d;
    logic [15:0]   bin_q, bin_d;
    logic [19:0]   bcd_q, bcd_d;
    logic [19:0]   adj;
    logic          hex_q, hex_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [6:0]    dig_q [4];
    logic [6:0]    dig_d [4];
    logic [CW-1:0] ref_q, ref_d;
    logic [1:0]    scan_q, scan_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Add-3 correction of every BCD nibble ahead of the shift.
    always_comb begin
        adj = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                      : bcd_q[4*i +: 4];
        end
    end

    // Conversion FSM: next state, shift datapath and digit register writes.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        hex_d   = hex_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        case (state_q)
            SHIFT: begin
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) state_d = COMMIT;
            end
            COMMIT: begin
                state_d = IDLE;
                if (hex_q) begin
                    for (int unsigned k = 0; k < 4; k++) dig_d[k] = seg7(bin_q[4*k +: 4]);
                end else if (bcd_q[19:16] != 4'd0) begin
                    for (int unsigned k = 0; k < 4; k++) dig_d[k] = SEG_DASH;
                end else begin
                    // A digit is blank only when it and every digit above it are zero.
                    dig_d[0] = seg7(bcd_q[3:0]);
                    dig_d[1] = (bcd_q[15:4]  == '0) ? SEG_BLANK : seg7(bcd_q[7:4]);
                    dig_d[2] = (bcd_q[15:8]  == '0) ? SEG_BLANK : seg7(bcd_q[11:8]);
                    dig_d[3] = (bcd_q[15:12] == '0) ? SEG_BLANK : seg7(bcd_q[15:12]);
                end
            end
            default: ;
        endcase
        // A load overrides any state transition but leaves a COMMIT write intact.
        if (bus.load) begin
            bin_d   = bus.value;
            hex_d   = bus.hex_mode;
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = bus.hex_mode ? COMMIT : SHIFT;
        end
    end

    // Free-running digit scan; decoded from next-cycle values so an and seg move together.
    always_comb begin
        ref_d  = (ref_q == LAST) ? '0 : ref_q + 1'b1;
        scan_d = (ref_q == LAST) ? scan_q + 2'd1 : scan_q;
        an_d   = ~(4'b0001 << scan_d);
        seg_d  = dig_d[scan_d];
    end

    // State and datapath registers.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            hex_q    <= 1'b0;
            cnt_q    <= '0;
            dig_q[0] <= SEG_ZERO;
            dig_q[1] <= SEG_BLANK;
            dig_q[2] <= SEG_BLANK;
            dig_q[3] <= SEG_BLANK;
            ref_q    <= '0;
            scan_q   <= '0;
            seg_q    <= SEG_ZERO;
            an_q     <= 4'b1110;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            hex_q   <= hex_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            ref_q   <= ref_d;
            scan_q  <= scan_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign bus.seg  = seg_q;
    assign bus.an   = an_q;
    assign bus.dp   = 1'b1;
    assign bus.busy = (state_q != IDLE);
endmodule

// File: tb/tb_calc_display.sv
// Scoreboard bench for calc_display: stimulus queues expected busy length and
// digit codes; a monitor checks them when busy falls and checks every scanned
// digit against the currently expected display on each cycle.
module tb_calc_display;
    localparam logic [6:0] B  = 7'b1111111;
    localparam logic [6:0] DS = 7'b0111111;

    typedef struct {
        int unsigned      len;
        logic [3:0][6:0]  d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    calc_display_if bus();

    calc_display #(.REFRESH_DIV(4)) dut (
        .CLK100MHZ (clk),
        .rst       (rst),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t        q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned done_cnt = 0;
    int unsigned target   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive_load(input logic [15:0] v, input logic h);
        bus.value    = v;
        bus.hex_mode = h;
        bus.load     = 1'b1;
        @(negedge clk);
        bus.load     = 1'b0;
    endtask

    task automatic wait_done();
        for (int c = 0; c < 300 && done_cnt < target; c++) @(negedge clk);
        chk("completion_timeout", done_cnt, target);
    endtask

    task automatic expect_item(input int unsigned len, input logic [3:0][6:0] d);
        exp_t e;
        e.len = len;
        e.d   = d;
        q.push_back(e);
        target++;
    endtask

    task automatic run(input logic [15:0] v, input logic h, input int unsigned len,
                       input logic [3:0][6:0] d);
        expect_item(len, d);
        drive_load(v, h);
        wait_done();
        repeat (20) @(negedge clk);
    endtask

    // Monitor: busy-length and digit checks, decoupled from stimulus.
    initial begin
        logic [3:0][6:0] last;
        int unsigned     bcnt;
        int unsigned     idx;
        exp_t            e;
        last = {B, B, B, 7'b1000000};
        bcnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bcnt = 0;
                last = {B, B, B, 7'b1000000};
                continue;
            end
            if (bus.busy) begin
                bcnt++;
            end else if (bcnt > 0) begin
                if (q.size() == 0) begin
                    chk("unexpected_conversion", 0, 1);
                end else begin
                    e = q.pop_front();
                    chk("busy_len", bcnt, e.len);
                    last = e.d;
                end
                done_cnt++;
                bcnt = 0;
            end
            case (bus.an)
                4'b1110: idx = 0;
                4'b1101: idx = 1;
                4'b1011: idx = 2;
                4'b0111: idx = 3;
                default: idx = 4;
            endcase
            if (idx == 4) chk("an_onehot", bus.an, 4'b1110);
            else          chk($sformatf("seg_digit%0d", idx), bus.seg, last[idx]);
            chk("dp", bus.dp, 1'b1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected < 1000000", $time);
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        logic [3:0] exp_an;
        bus.value    = '0;
        bus.hex_mode = 1'b0;
        bus.load     = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_an", bus.an, 4'b1110);
        chk("rst_seg", bus.seg, 7'b1000000);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_dp", bus.dp, 1'b1);
        rst = 1'b0;
        // Scan order: each digit lit for 4 cycles starting from release.
        for (int k = 0; k < 20; k++) begin
            #1;
            exp_an = ~(4'b0001 << ((k / 4) % 4));
            chk("scan_an", bus.an, exp_an);
            chk("idle_busy", bus.busy, 1'b0);
            @(negedge clk);
        end

        run(16'd1234, 1'b0, 17, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
        run(16'd7,    1'b0, 17, {B, B, B, 7'b1111000});
        run(16'd0,    1'b0, 17, {B, B, B, 7'b1000000});
        run(16'd1005, 1'b0, 17, {7'b1111001, 7'b1000000, 7'b1000000, 7'b0010010});
        run(16'h00FF, 1'b1, 1,  {7'b1000000, 7'b1000000, 7'b0001110, 7'b0001110});
        run(16'hA3C0, 1'b1, 1,  {7'b0001000, 7'b0110000, 7'b1000110, 7'b1000000});
        run(16'hBDE1, 1'b1, 1,  {7'b0000011, 7'b0100001, 7'b0000110, 7'b1111001});
        run(16'd10000, 1'b0, 17, {DS, DS, DS, DS});
        run(16'd9999,  1'b0, 17, {7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000});
        run(16'd65535, 1'b0, 17, {DS, DS, DS, DS});

        // Inputs changing without load while busy are ignored.
        expect_item(17, {B, B, 7'b0011001, 7'b0100100});
        drive_load(16'd42, 1'b0);
        repeat (3) @(negedge clk);
        bus.value    = 16'd9999;
        bus.hex_mode = 1'b1;
        wait_done();
        repeat (20) @(negedge clk);

        // Second load five cycles after the first discards the first conversion.
        expect_item(22, {B, B, B, 7'b0010000});
        drive_load(16'd1234, 1'b0);
        repeat (4) @(negedge clk);
        drive_load(16'd9, 1'b0);
        wait_done();
        repeat (20) @(negedge clk);

        // Asynchronous reset in the middle of SHIFT.
        drive_load(16'd1234, 1'b0);
        repeat (3) @(negedge clk);
        chk("busy_before_reset", bus.busy, 1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midshift_rst_an", bus.an, 4'b1110);
        chk("midshift_rst_seg", bus.seg, 7'b1000000);
        chk("midshift_rst_busy", bus.busy, 1'b0);
        chk("midshift_rst_dp", bus.dp, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        run(16'd56, 1'b0, 17, {B, B, 7'b0010010, 7'b0000010});

        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/calc_display.md
Name: calc_display

Overview:
Display-side consumer of the calculator's registered 16-bit result. It takes a captured result plus a load strobe and converts it to four digits: decimal via a sequential double-dabble (shift-add-3), or hex directly. It time-multiplexes the digits onto the board's 4-digit active-low 7-segment display. It sits between the result register and the board pins, and is driven by the same clock and the same "any button pressed" enable.

Parameters:
REFRESH_DIV, 100000, clock cycles each digit stays lit (1 kHz digit rate at 100 MHz); benches use 4.

Ports:
CLK100MHZ  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
value  input  16  unsigned result to display.
load  input  1  capture strobe; sampled on every rising edge.
hex_mode  input  1  1 = show 4 hex digits; 0 = show decimal. Captured with value.
seg  output  7  segments, active-low; bit0=a through bit6=g.
an  output  4  digit anodes, active-low; an[0] = least significant digit.
dp  output  1  decimal point, active-low; tied off (1).
busy  output  1  high while a conversion is in progress.

Behaviour:
- Reset (async, immediate): state IDLE; display digits 0,0,0,0 with digits 1-3 blanked; scan index 0; refresh count 0.
- Reset output values: an=1110, seg=1000000, dp=1, busy=0.
- FSM states: IDLE, SHIFT, COMMIT. busy = (state != IDLE).
- load=1 at an edge, from any state: capture value and hex_mode, then restart.
  - Decimal: go to SHIFT with the shift count cleared and the BCD accumulator zeroed.
  - Hex: go directly to COMMIT.
  - The latest load always wins; an in-flight conversion is discarded.
- SHIFT, one iteration per cycle: add 3 to every BCD nibble that is >=5, then shift {bcd[19:0], bin[15:0]} left by 1.
  - Exactly 16 iterations; after the 16th, go to COMMIT.
- COMMIT (1 cycle): write the display digit registers, then go to IDLE.
- Latency, with load sampled at edge 0:
  - Decimal: shifts occur on edges 1..16, commit on edge 17; busy is high for 17 cycles.
  - Hex: commit on edge 1; busy is high for 1 cycle.
- The display digit registers change only in COMMIT; the old result stays visible while busy.
- Decimal formatting:
  - If the ten-thousands digit != 0 (value > 9999), all four digits show '-' (seg 0111111).
  - Otherwise, leading-zero blanking: every digit above the most significant non-zero digit is blank (seg 1111111).
  - Digit 0 is always shown, so value 0 displays "0".
- Hex formatting: value[4k+3:4k] on digit k; no blanking.
- Segment codes (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On each wrap, the scan index advances 0→1→2→3→0.
  - an is a one-hot-low decode of the scan index; seg is the decoded digit at the scan index.
  - Both are registered, so they update together with no glitch cycle.
  - Scanning is free-running and independent of the FSM.
- Simultaneous load and COMMIT in the same cycle: the load wins. The COMMIT write still occurs, and the new conversion starts.
- value and hex_mode changing while busy are ignored unless load is asserted.

Test Plan:
1. Assert rst, release, run 20 cycles (REFRESH_DIV=4) -> an cycles 1110/1101/1011/0111 every 4 cycles; seg=1000000 on an=1110 and 1111111 on the other three; busy=0; dp=1.
2. value=1234, hex_mode=0, 1-cycle load -> busy high exactly 17 cycles, display unchanged until commit; afterwards an=1110:0011001, 1101:0110000, 1011:0100100, 0111:1111001.
3. value=7 decimal -> digit0 shows 1111000 and digits 1-3 show 1111111; then value=0 -> digit0 shows 1000000 and the rest are blank.
4. value=16'h00FF, hex_mode=1 -> busy high 1 cycle; digits 0,1 show 0001110 and digits 2,3 show 1000000.
5. value=10000 decimal -> all four digits show 0111111; value=9999 -> digits show 0010000 with none blanked.
6. Load 1234, then load 9 five cycles later -> busy stays high 17 cycles after the second load, and the display shows only "9". Separately, assert rst mid-SHIFT -> outputs take reset values in the same cycle and busy=0.
